// File: rtl/wb_sequencer_pkg.sv
// wb_sequencer_pkg: shared writeback types and constants
package wb_sequencer_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        LDM,
        LDM_BASE
    } state_t;

endpackage

// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: retire handshake, load-multiple beat and register-file write port
interface wb_sequencer_if;
    import wb_sequencer_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic              wb_rd_en;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_rd_data;
    logic              wb_rn_en;
    logic [REG_W-1:0]  wb_rn;
    logic [DATA_W-1:0] wb_rn_data;
    logic              wb_ldm;
    logic [15:0]       wb_reglist;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;

    modport master (
        output wb_valid, wb_rd_en, wb_rd, wb_rd_data, wb_rn_en, wb_rn, wb_rn_data,
               wb_ldm, wb_reglist, mem_valid, mem_data,
        input  wb_ready, mem_ready, write, write_reg, write_data
    );

    modport slave (
        input  wb_valid, wb_rd_en, wb_rd, wb_rd_data, wb_rn_en, wb_rn, wb_rn_data,
               wb_ldm, wb_reglist, mem_valid, mem_data,
        output wb_ready, mem_ready, write, write_reg, write_data
    );

endinterface

// File: rtl/wb_sequencer_lowest_set16.sv
// lowest_set16: index of the lowest set bit of a 16-bit vector, none when all clear
module lowest_set16
    import wb_sequencer_pkg::*;
(
    input  logic [15:0]      vec,
    output logic [REG_W-1:0] idx,
    output logic             none
);

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--)
            if (vec[i]) idx = REG_W'(i);
        none = ~|vec;
    end

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: serialises rd, base and load-multiple writes onto one register-file port
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int LDM_MAX = 16
)(
    input  logic          clk,
    input  logic          Nrst,
    wb_sequencer_if.slave bus,
    output logic          busy
);

    state_t             state, state_nx;
    logic [LDM_MAX-1:0] list, list_nx;
    logic               rn_en_q, rn_hit_q;
    logic [REG_W-1:0]   rn_q;
    logic [DATA_W-1:0]  rn_data_q;
    logic [REG_W-1:0]   low_idx;
    logic               low_none;
    logic               take;
    logic               issue;
    logic [REG_W-1:0]   issue_reg;
    logic [DATA_W-1:0]  issue_data;

    lowest_set16 u_low (
        .vec  (list),
        .idx  (low_idx),
        .none (low_none)
    );

    assign bus.wb_ready  = state == IDLE;
    assign bus.mem_ready = state == LDM;
    assign busy          = state != IDLE;
    assign take          = bus.wb_valid && state == IDLE;

    always_comb begin
        state_nx   = state;
        list_nx    = list;
        issue      = 1'b0;
        issue_reg  = rn_q;
        issue_data = rn_data_q;
        case (state)
            IDLE:
                if (bus.wb_valid) begin
                    if (bus.wb_ldm) begin
                        list_nx  = bus.wb_reglist;
                        state_nx = |bus.wb_reglist ? LDM : bus.wb_rn_en ? LDM_BASE : IDLE;
                    end else begin
                        issue      = bus.wb_rd_en || bus.wb_rn_en;
                        issue_reg  = bus.wb_rd_en ? bus.wb_rd : bus.wb_rn;
                        issue_data = bus.wb_rd_en ? bus.wb_rd_data : bus.wb_rn_data;
                        state_nx   = bus.wb_rd_en && bus.wb_rn_en ? SECOND : IDLE;
                    end
                end
            SECOND, LDM_BASE: begin
                issue    = 1'b1;
                state_nx = IDLE;
            end
            LDM:
                if (bus.mem_valid && !low_none) begin
                    issue      = 1'b1;
                    issue_reg  = low_idx;
                    issue_data = bus.mem_data;
                    list_nx    = list & ~(LDM_MAX'(1) << low_idx);
                    // a loaded base register overrides the writeback value
                    if (list_nx == '0)
                        state_nx = rn_en_q && !rn_hit_q ? LDM_BASE : IDLE;
                end
        endcase
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state          <= IDLE;
            list           <= '0;
            rn_en_q        <= 1'b0;
            rn_hit_q       <= 1'b0;
            rn_q           <= '0;
            rn_data_q      <= '0;
            bus.write      <= 1'b0;
            bus.write_reg  <= '0;
            bus.write_data <= '0;
        end else begin
            state     <= state_nx;
            list      <= list_nx;
            bus.write <= issue;
            if (take) begin
                rn_en_q   <= bus.wb_rn_en;
                rn_hit_q  <= bus.wb_reglist[bus.wb_rn];
                rn_q      <= bus.wb_rn;
                rn_data_q <= bus.wb_rn_data;
            end
            if (issue) begin
                bus.write_reg  <= issue_reg;
                bus.write_data <= issue_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed stimulus with a write scoreboard for wb_sequencer
module tb_wb_sequencer;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic Nrst = 1'b0;
    logic busy;
    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];

    wb_sequencer_if bus ();

    wb_sequencer #(.LDM_MAX(16)) dut (
        .clk  (clk),
        .Nrst (Nrst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [3:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic ldm, input logic rd_en, input logic [3:0] rd, input logic [31:0] rdd,
                         input logic rn_en, input logic [3:0] rn, input logic [31:0] rnd, input logic [15:0] list);
        bus.wb_valid   = 1'b1;
        bus.wb_ldm     = ldm;
        bus.wb_rd_en   = rd_en;
        bus.wb_rd      = rd;
        bus.wb_rd_data = rdd;
        bus.wb_rn_en   = rn_en;
        bus.wb_rn      = rn;
        bus.wb_rn_data = rnd;
        bus.wb_reglist = list;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.write) begin
            exp_t e;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_reg", 32'(bus.write_reg), 32'(e.r));
                check("write_data", bus.write_data, e.d);
            end
        end
    end

    initial begin
        bus.wb_valid = 1'b0; bus.wb_ldm = 1'b0; bus.wb_rd_en = 1'b0; bus.wb_rd = '0;
        bus.wb_rd_data = '0; bus.wb_rn_en = 1'b0; bus.wb_rn = '0; bus.wb_rn_data = '0;
        bus.wb_reglist = '0; bus.mem_valid = 1'b0; bus.mem_data = '0;
        repeat (2) step();
        check("rst_write", 32'(bus.write), 0);
        check("rst_write_reg", 32'(bus.write_reg), 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_mem_ready", 32'(bus.mem_ready), 0);
        Nrst = 1'b1;
        #1;
        check("rel_busy", 32'(busy), 0);
        check("rel_wb_ready", 32'(bus.wb_ready), 1);
        check("rel_write", 32'(bus.write), 0);

        // single rd write
        step();
        drive(0, 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 0, 16'h0);
        push(4'd3, 32'hDEADBEEF);
        step();
        bus.wb_valid = 1'b0;
        check("single_wb_ready", 32'(bus.wb_ready), 1);
        check("single_write", 32'(bus.write), 1);
        repeat (2) step();
        check("single_drained", 32'(exp_q.size()), 0);

        // two-write instruction with a second instruction held through the stall
        drive(0, 1, 4'd2, 32'h11, 1, 4'd5, 32'h1000, 16'h0);
        push(4'd2, 32'h11);
        push(4'd5, 32'h1000);
        step();
        check("two_wb_ready_low", 32'(bus.wb_ready), 0);
        drive(0, 1, 4'd7, 32'h77, 0, 4'd0, 0, 16'h0);
        push(4'd7, 32'h77);
        step();
        check("two_wb_ready_back", 32'(bus.wb_ready), 1);
        check("two_second_write", 32'(bus.write_reg), 32'd5);
        step();
        bus.wb_valid = 1'b0;
        check("held_write_reg", 32'(bus.write_reg), 32'd7);
        repeat (2) step();
        check("two_drained", 32'(exp_q.size()), 0);

        // stray beat outside LDM
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hBAD;
        #1;
        check("idle_mem_ready", 32'(bus.mem_ready), 0);
        repeat (2) step();
        bus.mem_valid = 1'b0;

        // LDM with a gap between beats and a base writeback
        drive(1, 1, 4'd9, 32'hFFFF, 1, 4'd13, 32'h200, 16'h0025);
        push(4'd0, 32'hA); push(4'd2, 32'hB); push(4'd5, 32'hC); push(4'd13, 32'h200);
        step();
        bus.wb_valid = 1'b0;
        check("ldm_mem_ready", 32'(bus.mem_ready), 1);
        check("ldm_wb_ready", 32'(bus.wb_ready), 0);
        check("ldm_busy", 32'(busy), 1);
        bus.mem_valid = 1'b1; bus.mem_data = 32'hA;
        step();
        bus.mem_valid = 1'b0;
        step();
        check("ldm_gap_write", 32'(bus.write), 0);
        bus.mem_valid = 1'b1; bus.mem_data = 32'hB;
        step();
        bus.mem_data = 32'hC;
        step();
        bus.mem_valid = 1'b0;
        check("ldm_base_wb_ready", 32'(bus.wb_ready), 0);
        check("ldm_base_mem_ready", 32'(bus.mem_ready), 0);
        step();
        check("ldm_done_busy", 32'(busy), 0);
        repeat (2) step();
        check("ldm_drained", 32'(exp_q.size()), 0);

        // LDM with the base register in the list
        drive(1, 0, 4'd0, 0, 1, 4'd13, 32'h999, 16'h2001);
        push(4'd0, 32'h51); push(4'd13, 32'h52);
        step();
        bus.wb_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_data = 32'h51;
        step();
        bus.mem_data = 32'h52;
        step();
        bus.mem_valid = 1'b0;
        check("hit_busy", 32'(busy), 0);
        repeat (3) step();
        check("hit_drained", 32'(exp_q.size()), 0);

        // reset in the middle of a load-multiple
        drive(1, 0, 4'd0, 0, 1, 4'd1, 32'h300, 16'h00F0);
        push(4'd4, 32'h61);
        step();
        bus.wb_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_data = 32'h61;
        step();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        #1;
        Nrst = 1'b0;
        #1;
        check("mid_rst_write", 32'(bus.write), 0);
        check("mid_rst_busy", 32'(busy), 0);
        repeat (2) step();
        Nrst = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_data = 32'h62;
        repeat (4) step();
        bus.mem_valid = 1'b0;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_write", 32'(bus.write), 0);
        check("post_rst_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Writeback sequencer that sits directly upstream of the register file and drives its single write port (`write`, `write_reg`, `write_data`). It accepts one retiring instruction per handshake and serialises its register writes onto that port, one write per cycle. The writes are the destination result, the base-register writeback, and load-multiple words streamed from the memory stage. Upstream is stalled through `wb_ready` while a multi-write instruction drains.

## Interface
Parameters:
- `LDM_MAX`, 16, width of the register list (fixed at 16; the parameter exists only for the bench).

Ports:
- `clk`  in  1  — the single clock; all state changes on its rising edge.
- `Nrst`  in  1  — reset, asynchronous and active-low.
- `wb_valid`  in  1  — an instruction is presented for retirement.
- `wb_ready`  out  1  — the sequencer accepts it this cycle.
- `wb_rd_en`  in  1  — the destination write is required.
- `wb_rd`  in  4  — destination register.
- `wb_rd_data`  in  32  — destination value.
- `wb_rn_en`  in  1  — the base-register writeback is required.
- `wb_rn`  in  4  — base register.
- `wb_rn_data`  in  32  — updated base value.
- `wb_ldm`  in  1  — load-multiple; `wb_rd_en`, `wb_rd` and `wb_rd_data` are ignored.
- `wb_reglist`  in  16  — load-multiple register list; bit i means register i.
- `mem_valid`  in  1  — a load-multiple data beat is present.
- `mem_data`  in  32  — the load-multiple data beat.
- `mem_ready`  out  1  — the beat is consumed this cycle.
- `write`  out  1  — register-file write enable (registered).
- `write_reg`  out  4  — register-file write index (registered).
- `write_data`  out  32  — register-file write data (registered).
- `busy`  out  1  — the state machine is not in IDLE.

## Operation
States: IDLE, SECOND, LDM, LDM_BASE.

IDLE:
- `wb_ready`=1; `mem_ready`=0.
- Handshake: `wb_valid`&&`wb_ready`.
- Non-LDM, `rd_en` only: issue the rd write; stay in IDLE.
- Non-LDM, `rn_en` only: issue the rn write; stay in IDLE.
- Non-LDM, both: issue rd now; latch rn and rn_data; go to SECOND.
- Non-LDM, neither: no write.
- LDM: latch `wb_reglist`, `rn_en`, `wb_rn` and `wb_rn_data`; go to LDM.
  - If the list is zero, go straight to LDM_BASE when rn_en=1, otherwise stay in IDLE.

SECOND:
- `wb_ready`=0.
- Issue the latched rn write; go to IDLE.

LDM:
- `wb_ready`=0; `mem_ready`=1.
- On each `mem_valid` beat, issue a write to the lowest set bit of the remaining list, then clear that bit.
- When the beat clears the last bit: go to LDM_BASE if rn_en=1 and the rn bit was not in the original list; otherwise go to IDLE.
- The base write is suppressed when rn is in the list, because the loaded value wins.
- No beat means no write and no state change.

LDM_BASE:
- `wb_ready`=0.
- Issue the rn write; go to IDLE.

Order rules:
- rd is always written before rn.
- Load-multiple beats are written in ascending register order.
- At most one write is issued per cycle.

## Timing
- "Issue" in cycle N means `write`, `write_reg` and `write_data` are valid in cycle N+1. The output register is loaded on the issuing edge; `write` is 0 in every cycle with no issue.
- Latency per instruction type:
  - Single write: one cycle.
  - Two-write instruction: writes in cycles N+1 and N+2; `wb_ready` is low in cycle N+1.
  - LDM with k registers: k write cycles, each one cycle after its beat, plus one more if base writeback applies. The next instruction is accepted in the cycle after the sequencer returns to IDLE.
- `wb_ready` and `mem_ready` are decoded from state only, with no combinational path from `wb_valid` or `mem_valid`.
- `mem_valid` while not in LDM is ignored and not consumed.
- Reset values:
  - State IDLE.
  - `write`=0, `write_reg`=0, `write_data`=0.
  - `busy`=0, `mem_ready`=0.
  - `wb_ready`=1 once reset is released.
- Reset asserted mid-operation abandons the latched list and pending rn immediately; no write is issued after release until a new handshake.

## Structure
- The shared CPU package holds the state enum (IDLE, SECOND, LDM, LDM_BASE) and the register-index width constant (4).
- One sub-module: `lowest_set16`, a combinational 16-bit priority encoder. It outputs a 4-bit index and a `none` flag, and is used to pick the next LDM register.

## Test plan
- Reset release: `write`=0, `busy`=0 and `wb_ready`=1 right after `Nrst` rises.
- Single rd write: rd_en, rd=3, data 0xDEADBEEF -> next cycle `write`=1, `write_reg`=3, `write_data`=0xDEADBEEF; `wb_ready` stays 1.
- Two-write instruction: rd=2/0x11 with rn=5/0x1000 -> writes (2,0x11) then (5,0x1000) in consecutive cycles; `wb_ready` is 0 for exactly one cycle; a second `wb_valid` held during it is accepted only afterward.
- LDM with gaps: reglist 0x0025, rn=13/0x200, beats 0xA, 0xB, 0xC with one idle cycle between the 1st and 2nd -> writes (0,0xA), (2,0xB), (5,0xC), (13,0x200); no write in the gap cycle.
- LDM with base in list: reglist 0x2001, rn=13 -> writes (0,beat0), (13,beat1) only; returns to IDLE with no base write.
- Reset mid-operation: assert `Nrst` low after the first beat of reglist 0x00F0 -> `write` drops to 0 asynchronously; after release, no further writes and `busy`=0.
